// File: rtl/key_sched_stream_if.sv
// Streaming handshake bundle for key_sched_stream.
// The mode signal exists only when KEY_SCHED_ENC_EN is defined.
interface key_sched_stream_if;
    logic         start;
    logic [111:0] key_in;
`ifdef KEY_SCHED_ENC_EN
    logic         mode;
`endif
    logic         key_ready;
    logic [95:0]  round_key;
    logic         key_valid;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

`ifdef KEY_SCHED_ENC_EN
    modport master (
        output start, key_in, mode, key_ready,
        input  round_key, key_valid, round_idx, busy, done
    );
    modport slave (
        input  start, key_in, mode, key_ready,
        output round_key, key_valid, round_idx, busy, done
    );
`else
    modport master (
        output start, key_in, key_ready,
        input  round_key, key_valid, round_idx, busy, done
    );
    modport slave (
        input  start, key_in, key_ready,
        output round_key, key_valid, round_idx, busy, done
    );
`endif
endinterface

// File: rtl/key_sched_stream.sv
// Streaming round-key generator over a 112-bit CD register (two DES-style PC-2 halves).
// Decrypt order by default; define KEY_SCHED_ENC_EN to add the mode input and encrypt order.
module key_sched_stream (
    input  logic              clk,
    input  logic              rst_n,
    key_sched_stream_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // DES PC-2 selection, 1-based from the MSB of each 56-bit half.
    localparam logic [5:0] PC2_TBL [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    state_t       state;
    logic [111:0] cd;
    logic [3:0]   idx_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;
    logic [3:0]   final_idx;
    logic         handshake;

    function automatic logic two_step(input logic [3:0] i);
        return !(i == 4'd0 || i == 4'd1 || i == 4'd8 || i == 4'd15);
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] q, input logic two);
        return two ? {q[1:0], q[27:2]} : {q[0], q[27:1]};
    endfunction

    function automatic logic [111:0] rotr_cd(input logic [111:0] v, input logic two);
        return {rotr28(v[111:84], two), rotr28(v[83:56], two),
                rotr28(v[55:28], two),  rotr28(v[27:0], two)};
    endfunction

    function automatic logic [47:0] pc2_half(input logic [55:0] h);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[6'(47 - i)] = h[6'd56 - PC2_TBL[i]];
        return r;
    endfunction

`ifdef KEY_SCHED_ENC_EN
    logic enc_q;

    function automatic logic [27:0] rotl28(input logic [27:0] q, input logic two);
        return two ? {q[25:0], q[27:26]} : {q[26:0], q[27]};
    endfunction

    function automatic logic [111:0] rotl_cd(input logic [111:0] v, input logic two);
        return {rotl28(v[111:84], two), rotl28(v[83:56], two),
                rotl28(v[55:28], two),  rotl28(v[27:0], two)};
    endfunction

    assign final_idx = enc_q ? 4'd15 : 4'd0;
`else
    assign final_idx = 4'd0;
`endif

    assign handshake = valid_q && bus.key_ready;

    // NOTE: all state below uses non-blocking assignment so every register
    // samples the pre-edge values; reset is synchronous and wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cd      <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef KEY_SCHED_ENC_EN
            enc_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef KEY_SCHED_ENC_EN
                        enc_q   <= bus.mode;
                        if (bus.mode) begin
                            cd    <= rotl_cd(bus.key_in, 1'b0);
                            idx_q <= 4'd0;
                        end else begin
                            cd    <= bus.key_in;
                            idx_q <= 4'd15;
                        end
`else
                        cd      <= bus.key_in;
                        idx_q   <= 4'd15;
`endif
                    end
                end
                RUN: begin
                    // The last key is consumed without a further rotation.
                    if (handshake) begin
                        if (idx_q == final_idx) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
`ifdef KEY_SCHED_ENC_EN
                        else if (enc_q) begin
                            cd    <= rotl_cd(cd, two_step(idx_q + 4'd1));
                            idx_q <= idx_q + 4'd1;
                        end
`endif
                        else begin
                            cd    <= rotr_cd(cd, two_step(idx_q));
                            idx_q <= idx_q - 4'd1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.round_key = {pc2_half(cd[111:56]), pc2_half(cd[55:0])};
    assign bus.key_valid = valid_q;
    assign bus.round_idx = idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_key_sched_stream.sv
// Scoreboard bench for key_sched_stream: a reference model queues the expected
// round keys at start time, and a negedge monitor pops them on each handshake.
module tb_key_sched_stream;

    typedef struct {
        logic [3:0]  idx;
        logic [95:0] key;
    } sb_entry_t;

    localparam int PC2_REF [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10, 23, 19, 12, 4,
        26, 8,  16, 7,  27, 20, 13, 2,  41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   last_idx = -1;
    sb_entry_t exp_q[$];
    sb_entry_t mon_e;

    key_sched_stream_if bus();

    key_sched_stream dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int s_of(input int i);
        return (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
    endfunction

    function automatic logic [27:0] q_rot(input logic [27:0] q, input int n, input bit left);
        logic [55:0] d;
        d = {q, q};
        if (left) begin
            d = d << n;
            return d[55:28];
        end
        d = d >> n;
        return d[27:0];
    endfunction

    function automatic logic [111:0] m_rot(input logic [111:0] v, input int n, input bit left);
        return {q_rot(v[111:84], n, left), q_rot(v[83:56], n, left),
                q_rot(v[55:28], n, left),  q_rot(v[27:0], n, left)};
    endfunction

    function automatic logic [47:0] m_pc2_half(input logic [55:0] h);
        logic [47:0] o;
        o = '0;
        for (int p = 1; p <= 48; p++) o[48 - p] = h[56 - PC2_REF[p - 1]];
        return o;
    endfunction

    function automatic logic [95:0] m_pc2(input logic [111:0] v);
        return {m_pc2_half(v[111:56]), m_pc2_half(v[55:0])};
    endfunction

    function automatic logic [111:0] rand_key();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[111:0];
    endfunction

    task automatic push_model(input logic [111:0] k, input bit enc);
        logic [111:0] cd;
        if (!enc) begin
            cd = k;
            for (int i = 15; i >= 0; i--) begin
                exp_q.push_back('{idx: 4'(i), key: m_pc2(cd)});
                if (i > 0) cd = m_rot(cd, s_of(i), 1'b0);
            end
        end else begin
            cd = m_rot(k, s_of(0), 1'b1);
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back('{idx: 4'(i), key: m_pc2(cd)});
                if (i < 15) cd = m_rot(cd, s_of(i + 1), 1'b1);
            end
        end
    endtask

    // Monitor: compares every valid cycle against the queue head, pops on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (bus.key_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_key", 128'(1), 128'(0));
                end else begin
                    mon_e = exp_q[0];
                    check("sb_idx", 128'(bus.round_idx), 128'(mon_e.idx));
                    check("sb_key", 128'(bus.round_key), 128'(mon_e.key));
                    if (bus.key_ready) begin
                        void'(exp_q.pop_front());
                        last_idx = int'(mon_e.idx);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [111:0] k, input bit enc);
        bus.start  = 1'b1;
        bus.key_in = k;
`ifdef KEY_SCHED_ENC_EN
        bus.mode   = enc;
`endif
        push_model(k, enc);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_to(input string tag, input logic [3:0] target);
        int n;
        n = 0;
        while (bus.round_idx !== target && n < 64) begin
            tick();
            n++;
        end
        check(tag, 128'(bus.round_idx), 128'(target));
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 128'(bus.done), 128'(1));
        tick();
        check({tag, "_done_one_cycle"}, 128'(bus.done), 128'(0));
        check({tag, "_sb_drained"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int d0;
        int b0;
        logic [111:0] k;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.key_in    = '0;
        bus.key_ready = 1'b0;
`ifdef KEY_SCHED_ENC_EN
        bus.mode      = 1'b0;
`endif
        repeat (2) tick();
        check("rst_valid", 128'(bus.key_valid), 128'(0));
        check("rst_busy",  128'(bus.busy),      128'(0));
        check("rst_done",  128'(bus.done),      128'(0));
        check("rst_idx",   128'(bus.round_idx), 128'(0));
        check("rst_key",   128'(bus.round_key), 128'(0));
        rst_n = 1'b1;
        tick();

        // Known-answer first keys, then the full single-key sequence.
        bus.key_ready = 1'b1;
        d0 = done_cnt;
        b0 = busy_cnt;
        start_seq(112'h1, 1'b0);
        check("k1_key", 128'(bus.round_key), 128'(96'h100));
        check("k1_idx", 128'(bus.round_idx), 128'(15));
        tick();
        check("k2_key", 128'(bus.round_key), 128'(96'h2));
        check("k2_idx", 128'(bus.round_idx), 128'(14));
        wait_done("dec_one");
        check("dec_one_done_pulses", 128'(done_cnt - d0), 128'(1));
        check("dec_one_busy_cycles", 128'(busy_cnt - b0), 128'(16));
        check("dec_one_last_idx", 128'(last_idx), 128'(0));

        // Random keys, each started in the first IDLE cycle after done.
        for (int t = 0; t < 3; t++) begin
            k  = rand_key();
            d0 = done_cnt;
            b0 = busy_cnt;
            start_seq(k, 1'b0);
            wait_done("dec_rand");
            check("dec_rand_done_pulses", 128'(done_cnt - d0), 128'(1));
            check("dec_rand_busy_cycles", 128'(busy_cnt - b0), 128'(16));
            check("dec_rand_final_cd", 128'(bus.round_key), 128'(m_pc2(m_rot(k, 27, 1'b0))));
        end

        // Backpressure at idx 9.
        k = rand_key();
        start_seq(k, 1'b0);
        run_to("bp_reach9", 4'd9);
        bus.key_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_idx", 128'(bus.round_idx), 128'(9));
            check("bp_hold_key", 128'(bus.round_key), 128'(exp_q[0].key));
        end
        bus.key_ready = 1'b1;
        tick();
        check("bp_resume_idx", 128'(bus.round_idx), 128'(8));
        wait_done("bp");

        // Start request while busy is ignored.
        k  = rand_key();
        d0 = done_cnt;
        start_seq(k, 1'b0);
        run_to("sb_reach7", 4'd7);
        bus.start  = 1'b1;
        bus.key_in = ~k;
        tick();
        bus.start = 1'b0;
        wait_done("start_busy");
        check("start_busy_done_pulses", 128'(done_cnt - d0), 128'(1));

        // Reset in the middle of a run.
        k = rand_key();
        start_seq(k, 1'b0);
        run_to("rst_reach4", 4'd4);
        rst_n = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", 128'(bus.key_valid), 128'(0));
        check("midrst_busy",  128'(bus.busy),      128'(0));
        check("midrst_key",   128'(bus.round_key), 128'(0));
        repeat (3) tick();
        check("midrst_no_done", 128'(done_cnt - d0), 128'(0));
        check("midrst_idle_valid", 128'(bus.key_valid), 128'(0));
        k = rand_key();
        start_seq(k, 1'b0);
        wait_done("after_rst");
        check("after_rst_done_pulses", 128'(done_cnt - d0), 128'(1));

`ifdef KEY_SCHED_ENC_EN
        // Encrypt order.
        d0 = done_cnt;
        start_seq(112'h1, 1'b1);
        check("enc_k1_key", 128'(bus.round_key), 128'(96'h40000));
        check("enc_k1_idx", 128'(bus.round_idx), 128'(0));
        wait_done("enc_one");
        check("enc_last_idx", 128'(last_idx), 128'(15));
        check("enc_done_pulses", 128'(done_cnt - d0), 128'(1));
        k = rand_key();
        start_seq(k, 1'b1);
        wait_done("enc_rand");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_sched_stream.md
KEY_SCHED_STREAM -- requirements
Module: key_sched_stream

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a new 16-key sequence; sampled only in IDLE.
REQ-004 SHALL have port key_in, input, 112 bits: post-PC-1 key (four 28-bit quarters [111:84], [83:56], [55:28], [27:0]), sampled with start.
REQ-005 SHALL have port key_ready, input, 1 bit: consumer accepts the current round key.
REQ-006 SHALL have port round_key, output, 96 bits: PC_2 compression of the internal 112-bit CD register.
REQ-007 SHALL have port key_valid, output, 1 bit: round_key and round_idx are valid.
REQ-008 SHALL have port round_idx, output, 4 bits: 0-based round number of round_key (0 = K1, 15 = K16).
REQ-009 SHALL have port busy, output, 1 bit: high in RUN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse after the last key is accepted.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 SHALL move IDLE->RUN when start=1: CD<=key_in, round_idx<=15, key_valid=1 on the next cycle (1-cycle latency).
REQ-013 SHALL drive round_key combinationally from CD through the PC_2 block; no extra register stage.
REQ-014 SHALL define a handshake as key_valid && key_ready on a rising edge; the round advances only on a handshake.
REQ-015 SHALL define shift s(i)=1 for i in {0,1,8,15}, else s(i)=2.
REQ-016 SHALL, in decrypt order, on a handshake at idx i>0, rotate each 28-bit quarter right by s(i) and set round_idx<=i-1. Right rotation moves bit k->k-1 and the quarter LSB->quarter MSB.
REQ-017 SHALL, on a handshake at the final index, go to DONE with key_valid=0; in DONE, done=1 for exactly one cycle, then return to IDLE.
REQ-018 SHALL hold CD, round_key and round_idx stable while key_valid=1 and key_ready=0.
REQ-019 SHALL ignore start in RUN and DONE; the sequence in progress is unaffected.
REQ-020 SHALL accept start in IDLE in the cycle immediately after done.
REQ-021 SHALL never rotate quarters across quarter boundaries.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, force state=IDLE, CD=0, round_idx=0, key_valid=0, busy=0 and done=0; round_key is therefore 0.
REQ-023 SHALL let reset override start and the handshake in the same cycle; reset mid-RUN abandons the sequence with no done pulse.

Configuration
REQ-024 SHALL, with KEY_SCHED_ENC_EN defined, add input port mode (1 bit, sampled with start): mode=1 selects encrypt order and mode=0 selects decrypt order.
REQ-025 SHALL, in encrypt order, load CD<=rotl(key_in, s(0)) per quarter with round_idx<=0. Each handshake at idx i<15 rotates left by s(i+1) and increments round_idx; the final index is 15.
REQ-026 SHALL, with KEY_SCHED_ENC_EN undefined, have no mode port and support decrypt order only (final index 0).

Verification
REQ-027 SHALL cover decrypt first keys: key_in=112'h1, start, key_ready=1 -> cycle+1 round_key=96'h100 with idx 15; next cycle round_key=96'h2 with idx 14.
REQ-028 SHALL cover full decrypt sequence: random key_in, key_ready=1 -> 16 consecutive valid cycles, idx 15..0 matching a reference model. The CD register after the last handshake equals key_in rotated right by 27 (total rotation 28 with the last step omitted). done pulses once; busy is high for 16 cycles.
REQ-029 SHALL cover backpressure: key_ready=0 for 5 cycles at idx 9 -> round_key and idx unchanged; resuming yields idx 8 with no key skipped or repeated.
REQ-030 SHALL cover start while busy: start=1 with a different key_in at idx 7 -> sequence continues unchanged to done.
REQ-031 SHALL cover reset mid-run: rst_n=0 for 1 cycle at idx 4 -> next cycle key_valid=0, busy=0, round_key=0, no done pulse; a new start works normally.
REQ-032 SHALL cover encrypt mode (KEY_SCHED_ENC_EN defined): key_in=112'h1, mode=1 -> first round_key=96'h40000 with idx 0; done follows the handshake at idx 15.
